// File: rtl/cv_btn_ctrl.sv
// cv_btn_ctrl: front-panel command controller for the sequence generator.
// Generates the button-filter sampling enable, captures filtered presses,
// adds hold-to-repeat on the most recently pressed button, and arbitrates
// pending presses round-robin into a small command FIFO drained by the core.
//
// Command handshake: CMD_VALID is high whenever the FIFO is non-empty and
// CMD_ID/CMD_RPT then hold the head entry. The head is consumed at a rising
// CLK edge where CMD_VALID & CMD_READY are both high. CMD_VALID never drops
// without a transfer except on RST, and the head is stable while it is waiting.
module cv_btn_ctrl #(
    parameter int N_BTN      = 4,
    parameter int CE_DIV     = 48000,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     CE_OUT,
    input  logic [N_BTN-1:0]         BTN_LVL,
    input  logic [N_BTN-1:0]         BTN_CEO,
    output logic                     CMD_VALID,
    output logic [$clog2(N_BTN)-1:0] CMD_ID,
    output logic                     CMD_RPT,
    input  logic                     CMD_READY,
    output logic                     OVF
);

    localparam int IDW  = $clog2(N_BTN);
    localparam int CW   = $clog2(CE_DIV + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int OW   = AW + 1;
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_DELAY  = 2'd1,
        RS_REPEAT = 2'd2
    } rpt_state_e;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce;

    // Terminal-count decode and wrap of the sampling prescaler.
    always_comb begin
        ce    = (cnt_q == CW'(CE_DIV - 1));
        cnt_d = ce ? '0 : cnt_q + 1'b1;
    end

    // Prescaler counter register.
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign CE_OUT = ce;

    // ------------------------------------------------------------------
    // State declarations
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] rpt_q, rpt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             ovf_q, ovf_d;

    logic [IDW:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic             fifo_full, fifo_empty, push, pop;

    rpt_state_e       rs_q;
    logic [IDW-1:0]   trk_q;
    logic [RW-1:0]    rcnt_q;

    logic             gnt_vld, gnt_rpt;
    logic [IDW-1:0]   gnt_id;
    logic [N_BTN-1:0] gnt_oh;
    int               scan_idx;

    assign fifo_full  = (occ_q == OW'(FIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pending bit at or above ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        gnt_oh   = '0;
        scan_idx = 0;
        if (!fifo_full) begin
            for (int k = 0; k < N_BTN; k++) begin
                scan_idx = (int'(ptr_q) + k) % N_BTN;
                if (!gnt_vld && pend_q[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = IDW'(scan_idx);
                end
            end
        end
        if (gnt_vld) gnt_oh[gnt_id] = 1'b1;
    end

    assign gnt_rpt = gnt_vld & rpt_q[gnt_id];
    assign push    = gnt_vld;
    assign pop     = CMD_VALID & CMD_READY;

    // ------------------------------------------------------------------
    // Repeat tracking decode
    // ------------------------------------------------------------------
    logic             new_press, trk_rel, retrack, fire;
    logic [RW-1:0]    lim_m1;
    logic [N_BTN-1:0] rep_set, press_set;

    assign new_press = gnt_vld & ~gnt_rpt;
    assign trk_rel   = ~BTN_LVL[trk_q];
    assign retrack   = new_press & (gnt_id != trk_q);
    assign lim_m1    = (rs_q == RS_DELAY) ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1);
    // A release or retrack in the same cycle cancels the repeat of the old button.
    assign fire      = (rs_q != RS_IDLE) & ~trk_rel & ~retrack & ce & (rcnt_q == lim_m1);
    assign press_set = BTN_CEO & BTN_LVL;

    // One-hot repeat request for the tracked button.
    always_comb begin
        rep_set = '0;
        if (fire) rep_set[trk_q] = 1'b1;
    end

    // Pending/repeat-flag/pointer/overflow next state. A new event on a bit
    // that is also granted this cycle re-arms it rather than being lost.
    always_comb begin
        pend_d = (pend_q & ~gnt_oh) | press_set | rep_set;
        rpt_d  = ~press_set & (rep_set | (rpt_q & ~gnt_oh));
        ovf_d  = ovf_q | (|((press_set | rep_set) & pend_q & ~gnt_oh));
        ptr_d  = ptr_q;
        if (gnt_vld) ptr_d = (gnt_id == IDW'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
    end

    // Capture and arbitration registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= '0;
            rpt_q  <= '0;
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            rpt_q  <= rpt_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Command FIFO: a push is only ever issued when not full, so a
    // simultaneous pop while full never lets a push through.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {gnt_rpt, gnt_id};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

    // Repeat FSM: tracks the last genuinely pressed button and counts CE ticks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rs_q   <= RS_IDLE;
            trk_q  <= '0;
            rcnt_q <= '0;
        end else begin
            case (rs_q)
                RS_IDLE: begin
                    if (new_press) begin
                        trk_q  <= gnt_id;
                        rcnt_q <= '0;
                        rs_q   <= RS_DELAY;
                    end
                end
                default: begin
                    if (trk_rel) begin
                        rcnt_q <= '0;
                        rs_q   <= RS_IDLE;
                    end else if (retrack) begin
                        trk_q  <= gnt_id;
                        rcnt_q <= '0;
                        rs_q   <= RS_DELAY;
                    end else if (ce) begin
                        if (rcnt_q == lim_m1) begin
                            rcnt_q <= '0;
                            rs_q   <= RS_REPEAT;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head fields are forced to 0 while empty so reset values are 0.
    // ------------------------------------------------------------------
    assign CMD_VALID = ~fifo_empty;
    assign CMD_ID    = fifo_empty ? '0 : mem_q[rd_ptr_q][IDW-1:0];
    assign CMD_RPT   = fifo_empty ? 1'b0 : mem_q[rd_ptr_q][IDW];
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_cv_btn_ctrl.sv
// Testbench for cv_btn_ctrl: directed phases for the prescaler, single press,
// round-robin order, backpressure/overflow, auto-repeat and mid-run reset,
// followed by randomized button traffic. A transaction-level reference model
// predicts every command; a monitor pops and compares on each handshake.
module tb_cv_btn_ctrl;

  localparam int NB   = 4;
  localparam int CED  = 5;
  localparam int DEP  = 4;
  localparam int RDLY = 3;
  localparam int RPER = 2;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce_out;
  logic [NB-1:0] btn_lvl = '0;
  logic [NB-1:0] btn_ceo = '0;
  logic          cmd_valid;
  logic [IDW-1:0] cmd_id;
  logic          cmd_rpt;
  logic          cmd_ready = 1'b0;
  logic          ovf;

  always #5 clk = ~clk;

  cv_btn_ctrl #(
    .N_BTN(NB), .CE_DIV(CED), .FIFO_DEPTH(DEP),
    .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .CLK(clk), .RST(rst), .CE_OUT(ce_out),
    .BTN_LVL(btn_lvl), .BTN_CEO(btn_ceo),
    .CMD_VALID(cmd_valid), .CMD_ID(cmd_id), .CMD_RPT(cmd_rpt),
    .CMD_READY(cmd_ready), .OVF(ovf)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  logic [NB-1:0] lvl = '0;

  logic [IDW:0] exp_q[$];
  int log_id[$];
  int log_rpt[$];
  int log_cyc[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Commands are what the panel should produce: presses queue up in a
  // pending set, the set is served round-robin whenever there is room,
  // and the last genuinely pressed button re-fires after a tick countdown.
  int            m_cyc  = 0;
  int            m_occ  = 0;
  logic [NB-1:0] m_pend = '0;
  logic [NB-1:0] m_rpt  = '0;
  int            m_ptr  = 0;
  int            m_trk  = -1;
  int            m_left = 0;
  bit            m_ovf  = 1'b0;

  function automatic bit pend_any();
    return (m_pend != '0);
  endfunction

  always @(posedge clk) begin
    int  g;
    int  idx;
    int  fire;
    bit  ce, full, pop, grpt, newp, press, rep, granted;
    if (rst) begin
      m_cyc = 0; m_occ = 0; m_pend = '0; m_rpt = '0;
      m_ptr = 0; m_trk = -1; m_left = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      ce   = ((m_cyc % CED) == CED - 1);
      full = (m_occ == DEP);
      pop  = (m_occ > 0) && cmd_ready;
      g    = -1;
      if (!full) begin
        for (int k = 0; k < NB; k++) begin
          idx = (m_ptr + k) % NB;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      end
      grpt = (g >= 0) ? m_rpt[g] : 1'b0;
      if (g >= 0) begin
        exp_q.push_back({grpt, IDW'(g)});
        m_ptr = (g + 1) % NB;
      end
      newp = (g >= 0) && !grpt;
      fire = -1;
      if (m_trk >= 0) begin
        if (!btn_lvl[m_trk]) m_trk = -1;
        else if (newp && g != m_trk) begin m_trk = g; m_left = RDLY; end
        else if (ce) begin
          m_left = m_left - 1;
          if (m_left == 0) begin fire = m_trk; m_left = RPER; end
        end
      end else if (newp) begin
        m_trk = g; m_left = RDLY;
      end
      for (int i = 0; i < NB; i++) begin
        press   = btn_ceo[i] && btn_lvl[i];
        rep     = (fire == i);
        granted = (g == i);
        if ((press || rep) && m_pend[i] && !granted) m_ovf = 1'b1;
        if (press)        begin m_pend[i] = 1'b1; m_rpt[i] = 1'b0; end
        else if (rep)     begin m_pend[i] = 1'b1; m_rpt[i] = 1'b1; end
        else if (granted) begin m_pend[i] = 1'b0; m_rpt[i] = 1'b0; end
      end
      m_occ = m_occ - (pop ? 1 : 0) + ((g >= 0) ? 1 : 0);
      m_cyc = m_cyc + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [IDW:0] e;
    if (chk_en) begin
      check("ce_out", ce_out, ((m_cyc % CED) == CED - 1) ? 1 : 0);
      check("cmd_valid", cmd_valid, (m_occ > 0) ? 1 : 0);
      check("ovf", ovf, m_ovf ? 1 : 0);
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("cmd_unexpected", int'({cmd_rpt, cmd_id}), -1);
        end else begin
          e = exp_q.pop_front();
          check("cmd_head", int'({cmd_rpt, cmd_id}), int'(e));
        end
        log_id.push_back(int'(cmd_id));
        log_rpt.push_back(int'(cmd_rpt));
        log_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input logic [NB-1:0] m);
    lvl     = lvl | m;
    btn_lvl = lvl;
    btn_ceo = m;
    tick();
    btn_ceo = '0;
  endtask

  task automatic rel_btn(input logic [NB-1:0] m);
    lvl     = lvl & ~m;
    btn_lvl = lvl;
    btn_ceo = m;
    tick();
    btn_ceo = '0;
  endtask

  task automatic log_clear();
    log_id.delete();
    log_rpt.delete();
    log_cyc.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_occ != 0 || pend_any()) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic check_order(input string name, input int n, input int e[6]);
    check(name, log_id.size(), n);
    for (int k = 0; k < n; k++)
      check(name, (k < log_id.size()) ? log_id[k] : -1, e[k]);
  endtask

  // Caller has just released RST one step after a reset edge.
  task automatic ce_after_reset(input int ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cmd_id", cmd_id, 0);
        check("rst_cmd_rpt", cmd_rpt, 0);
      end
      check("ce_out_cycle", ce_out, ((i % CED) == 0) ? 1 : 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e[6];
    int n0;
    int n;
    int gap;
    logic [NB-1:0] mask;

    // Reset and prescaler phase
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    ce_after_reset(15);

    // Single press on button 2
    cmd_ready = 1'b1;
    tick();
    press_btn(4'b0100);
    @(negedge clk);
    check("press_valid_c1", cmd_valid, 0);
    @(negedge clk);
    check("press_valid_c2", cmd_valid, 1);
    check("press_id", cmd_id, 2);
    check("press_rpt", cmd_rpt, 0);
    @(negedge clk);
    check("press_valid_c3", cmd_valid, 0);
    tick();
    rel_btn(4'b0100);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_valid) n++;
    end
    check("release_no_cmd", n, 0);
    tick();

    // Round-robin from ptr=0
    press_btn(4'b1000);
    rel_btn(4'b1000);
    wait_idle(50);
    log_clear();
    press_btn(4'b1011);
    rel_btn(4'b1011);
    wait_idle(50);
    e = '{0, 1, 3, 0, 0, 0};
    check_order("rr_from_0", 3, e);
    check("rr_consecutive", (log_cyc.size() == 3) ? log_cyc[2] - log_cyc[0] : -1, 2);

    // Round-robin from ptr=2
    press_btn(4'b0010);
    rel_btn(4'b0010);
    wait_idle(50);
    log_clear();
    press_btn(4'b1011);
    rel_btn(4'b1011);
    wait_idle(50);
    e = '{3, 0, 1, 0, 0, 0};
    check_order("rr_from_2", 3, e);

    // Backpressure: six presses into a 4-deep FIFO, then a lost press
    cmd_ready = 1'b0;
    log_clear();
    press_btn(4'b0001); rel_btn(4'b0001);
    press_btn(4'b0010); rel_btn(4'b0010);
    press_btn(4'b0100); rel_btn(4'b0100);
    press_btn(4'b1000); rel_btn(4'b1000);
    press_btn(4'b0001); rel_btn(4'b0001);
    press_btn(4'b0010); rel_btn(4'b0010);
    @(negedge clk);
    check("bp_valid", cmd_valid, 1);
    check("bp_ovf_before", ovf, 0);
    tick();
    press_btn(4'b0001);
    @(negedge clk);
    check("bp_ovf_after", ovf, 1);
    tick();
    rel_btn(4'b0001);
    cmd_ready = 1'b1;
    wait_idle(100);
    e = '{0, 1, 2, 3, 0, 1};
    check_order("bp_drain", 6, e);

    // Auto-repeat on a held button 1
    log_clear();
    press_btn(4'b0010);
    n = 0;
    while (log_id.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    check("rpt_three_cmds", (log_id.size() >= 3) ? 1 : 0, 1);
    if (log_id.size() >= 3) begin
      check("rpt_id0", log_id[0], 1);
      check("rpt_flag0", log_rpt[0], 0);
      check("rpt_id1", log_id[1], 1);
      check("rpt_flag1", log_rpt[1], 1);
      check("rpt_flag2", log_rpt[2], 1);
      gap = log_cyc[1] - log_cyc[0];
      if (gap < RDLY * CED - CED + 2 || gap > RDLY * CED + 1)
        $display("first repeat gap %0d cycles", gap);
      check("rpt_first_gap_in_range",
            (gap >= RDLY * CED - CED + 2 && gap <= RDLY * CED + 1) ? 1 : 0, 1);
      check("rpt_period", log_cyc[2] - log_cyc[1], RPER * CED);
    end
    rel_btn(4'b0010);
    repeat (3) tick();
    n0 = log_id.size();
    repeat (40) tick();
    check("no_rpt_after_release", log_id.size(), n0);

    // Reset mid-operation: 3 FIFO entries and the repeat FSM past its first repeat
    cmd_ready = 1'b0;
    press_btn(4'b1000);
    rel_btn(4'b1000);
    press_btn(4'b0001);
    n = 0;
    while (m_occ < 3 && n < 200) begin
      tick();
      n++;
    end
    check("rst_setup_three_entries", m_occ, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ce_after_reset(10);
    cmd_ready = 1'b1;
    tick();
    n0 = log_id.size();
    repeat (40) tick();
    check("rst_no_cmd_after", log_id.size(), n0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_ready = ($urandom_range(0, 99) < ((i < 1500) ? 80 : 30));
      mask = '0;
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 19) == 0) mask[b] = 1'b1;
      lvl     = lvl ^ mask;
      btn_lvl = lvl;
      btn_ceo = mask;
      tick();
    end
    btn_ceo = '0;
    if (lvl != '0) rel_btn(lvl);
    cmd_ready = 1'b1;
    wait_idle(300);
    repeat (5) tick();
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
